// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the BCD clock outputs.
// Snapshots the time once per frame and adds blanking, zero suppression and dots.
module clock_display_scan #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLANK_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_units,
    input  logic [3:0] hour_tens,
    input  logic       is_am,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int DIGIT_TICKS = CLK_FREQ / SCAN_HZ;
    localparam int CW          = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

    typedef logic [CW-1:0] tick_t;
    localparam tick_t LAST_TICK  = tick_t'(DIGIT_TICKS - 1);
    localparam tick_t BLANK_TICK = tick_t'(BLANK_TICKS);

    // Slot order matches anode bit order: an[0] = sec_units ... an[5] = hour_tens.
    typedef enum logic [2:0] {
        SLOT_SU = 3'd0,
        SLOT_ST = 3'd1,
        SLOT_MU = 3'd2,
        SLOT_MT = 3'd3,
        SLOT_HU = 3'd4,
        SLOT_HT = 3'd5
    } slot_t;

    typedef struct packed {
        logic [3:0] su;
        logic [3:0] st;
        logic [3:0] mu;
        logic [3:0] mt;
        logic [3:0] hu;
        logic [3:0] ht;
        logic       am;
    } shadow_t;

    tick_t   c;
    slot_t   s;
    shadow_t shadow;

    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic       frame_d;
    logic [3:0] digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    assign frame_d = (s == SLOT_SU) && (c == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        an_d  = 6'b111111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        digit = 4'd0;
        if (c >= BLANK_TICK) begin
            an_d = ~(6'b000001 << s);
            case (s)
                SLOT_SU: digit = shadow.su;
                SLOT_ST: digit = shadow.st;
                SLOT_MU: digit = shadow.mu;
                SLOT_MT: digit = shadow.mt;
                SLOT_HU: digit = shadow.hu;
                SLOT_HT: digit = shadow.ht;
                default: digit = 4'd0;
            endcase
            seg_d = seg_decode(digit);
            // Suppressed leading zero keeps its anode on so every digit sees equal duty.
            if (s == SLOT_HT && shadow.ht == 4'd0)
                seg_d = 7'b1111111;
            case (s)
                SLOT_ST: dp_d = shadow.su[0];
                SLOT_MU: dp_d = 1'b0;
                SLOT_HU: dp_d = shadow.am;
                default: dp_d = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= '0;
            s <= SLOT_SU;
        end else if (c == LAST_TICK) begin
            c <= '0;
            s <= (s == SLOT_HT) ? SLOT_SU : slot_t'(s + 3'd1);
        end else begin
            c <= c + tick_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_d) begin
            shadow <= '{su: sec_units, st: sec_tens, mu: min_units, mt: min_tens,
                        hu: hour_units, ht: hour_tens, am: is_am};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 6'b111111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frame_d;
        end
    end

endmodule
